// File: rtl/hal_timer_sequencer.sv
// Avalon-MM master sequencing start/stop/snapshot/poll accesses to an interval-timer slave.
// Optional tick counter enabled by defining HAL_TIMER_TICK_COUNT_EN.
module hal_timer_sequencer #(
  parameter int unsigned CONT_MODE  = 1,
  parameter int unsigned POLL_GAP   = 0,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] cfg_period,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  output logic        cmd_ready,
  output logic        running,
  output logic        tick,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic [15:0] tick_count,
  output logic [2:0]  hal_timer_address,
  output logic [15:0] hal_timer_writedata,
  input  logic [15:0] hal_timer_readdata,
  output logic        hal_timer_chipselect,
  output logic        hal_timer_write_n
);

  typedef enum logic [3:0] {
    StIdle, StWrPl, StWrPh, StWrCtl, StPollGap, StPollRd, StPollSmp,
    StClrTo, StWrStop, StSnapW, StSnapRl, StSnapSl, StSnapRh, StSnapSh
  } state_e;

  localparam logic [7:0]  GapLoad  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam logic        ContBit  = (CONT_MODE != 0);
  localparam logic [15:0] CtlStart = {12'd0, 1'b0, 1'b1, ContBit, 1'b0};
  localparam logic [15:0] CtlStop  = 16'h0008;
  localparam logic [31:0] MinP     = 32'(MIN_PERIOD);
  // With no gap the poll loop enters the read directly.
  localparam state_e      PollNext = (POLL_GAP == 0) ? StPollRd : StPollGap;

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] period_q, period_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] p_in;

  assign p_in = ((cfg_period < MinP) ? MinP : cfg_period) - 32'd1;

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    period_d     = period_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    running_d    = running_q;

    unique case (state_q)
      StIdle:    state_d = StIdle;
      StWrPl:    state_d = StWrPh;
      StWrPh:    state_d = StWrCtl;
      StWrCtl: begin
        running_d = 1'b1;
        state_d   = PollNext;
      end
      StPollGap: begin
        if (gap_q == 8'd0) state_d = StPollRd;
        else               gap_d   = gap_q - 8'd1;
      end
      StPollRd:  state_d = StPollSmp;
      StPollSmp: state_d = hal_timer_readdata[0] ? StClrTo : PollNext;
      StClrTo: begin
        if (CONT_MODE == 0) begin
          running_d = 1'b0;
          state_d   = StIdle;
        end else begin
          state_d = PollNext;
        end
      end
      StWrStop: begin
        running_d = 1'b0;
        state_d   = StIdle;
      end
      StSnapW:   state_d = StSnapRl;
      StSnapRl:  state_d = StSnapSl;
      StSnapSl: begin
        snap_lo_d = hal_timer_readdata;
        state_d   = StSnapRh;
      end
      StSnapRh:  state_d = StSnapSh;
      StSnapSh: begin
        snap_value_d = {hal_timer_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = running_q ? PollNext : StIdle;
      end
      default:   state_d = StIdle;
    endcase

    // cmd_ready_q is high exactly in Idle/PollGap/PollRd; commands preempt the poll.
    if (cmd_ready_q) begin
      if (cmd_stop) begin
        state_d = StWrStop;
      end else if (cmd_start) begin
        state_d  = StWrPl;
        period_d = p_in;
      end else if (cmd_snap) begin
        state_d = StSnapW;
      end
    end

    if (state_d == StPollGap && state_q != StPollGap) gap_d = GapLoad;
  end

  // Bus and status outputs are registered from the next state.
  always_comb begin
    cmd_ready_d = (state_d == StIdle) || (state_d == StPollGap) || (state_d == StPollRd);
    tick_d      = (state_d == StClrTo);
    cs_d        = 1'b0;
    wn_d        = 1'b1;
    addr_d      = 3'd0;
    wd_d        = 16'd0;
    case (state_d)
      StWrPl:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0];  end
      StWrPh:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_d[31:16]; end
      StWrCtl:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CtlStart;        end
      StPollRd: begin cs_d = 1'b1; addr_d = 3'd0;                                      end
      StClrTo:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;                         end
      StWrStop: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CtlStop;         end
      StSnapW:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;                         end
      StSnapRl: begin cs_d = 1'b1; addr_d = 3'd4;                                      end
      StSnapRh: begin cs_d = 1'b1; addr_d = 3'd5;                                      end
      default:  cs_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      gap_q        <= 8'd0;
      period_q     <= 32'd0;
      snap_lo_q    <= 16'd0;
      snap_value_q <= 32'd0;
      snap_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      cmd_ready_q  <= 1'b1;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 3'd0;
      wd_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      period_q     <= period_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      cmd_ready_q  <= cmd_ready_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
    end
  end

`ifdef HAL_TIMER_TICK_COUNT_EN
  logic [15:0] tick_count_q, tick_count_d;
  logic        start_acc;

  assign start_acc = cmd_ready_q & cmd_start & ~cmd_stop;

  always_comb begin
    tick_count_d = tick_count_q;
    if (start_acc)                                tick_count_d = 16'd0;
    else if (tick_d && tick_count_q != 16'hFFFF) tick_count_d = tick_count_q + 16'd1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) tick_count_q <= 16'd0;
    else             tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = 16'd0;
`endif

  assign cmd_ready            = cmd_ready_q;
  assign running              = running_q;
  assign tick                 = tick_q;
  assign snap_value           = snap_value_q;
  assign snap_valid           = snap_valid_q;
  assign hal_timer_chipselect = cs_q;
  assign hal_timer_write_n    = wn_q;
  assign hal_timer_address    = addr_q;
  assign hal_timer_writedata  = wd_q;

endmodule

// File: tb/tb_hal_timer_sequencer.sv
// Scoreboard bench for hal_timer_sequencer: stimulus queues expected bus accesses and snapshots,
// a negedge monitor pops and compares them against the DUT; a small timer slave model responds.
module tb_hal_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [31:0] cfg_period;
  logic        cmd_start, cmd_stop, cmd_snap;
  logic        cmd_ready, running, tick, snap_valid;
  logic [31:0] snap_value;
  logic [15:0] tick_count;
  logic [2:0]  addr;
  logic [15:0] wdata, rdata;
  logic        cs, wn;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        exp_q[$];
  logic [31:0] snap_exp_q[$];

  localparam logic [31:0] SnapConst = 32'h1234_ABCD;

  hal_timer_sequencer dut (
    .clk_clk              (clk),
    .reset_reset          (reset_reset),
    .cfg_period           (cfg_period),
    .cmd_start            (cmd_start),
    .cmd_stop             (cmd_stop),
    .cmd_snap             (cmd_snap),
    .cmd_ready            (cmd_ready),
    .running              (running),
    .tick                 (tick),
    .snap_value           (snap_value),
    .snap_valid           (snap_valid),
    .tick_count           (tick_count),
    .hal_timer_address    (addr),
    .hal_timer_writedata  (wdata),
    .hal_timer_readdata   (rdata),
    .hal_timer_chipselect (cs),
    .hal_timer_write_n    (wn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval-timer slave model with read latency 1.
  logic [15:0] m_pl, m_ph;
  logic [31:0] m_cnt, m_snap;
  logic        m_run, m_cont, m_to;
  always @(posedge clk) begin
    if (reset_reset) begin
      m_pl <= 0; m_ph <= 0; m_cnt <= 0; m_snap <= 0;
      m_run <= 0; m_cont <= 0; m_to <= 0; rdata <= 0;
    end else begin
      if (m_run) begin
        if (m_cnt == 0) begin
          m_to  <= 1'b1;
          m_cnt <= {m_ph, m_pl};
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (cs && !wn) begin
        case (addr)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            if (wdata[2]) begin m_run <= 1'b1; m_cont <= wdata[1]; m_cnt <= {m_ph, m_pl}; end
            if (wdata[3]) m_run <= 1'b0;
          end
          3'd2: m_pl <= wdata;
          3'd3: m_ph <= wdata;
          3'd4: m_snap <= SnapConst;
          default: ;
        endcase
      end
      if (cs && wn) begin
        case (addr)
          3'd0:    rdata <= {15'd0, m_to};
          3'd4:    rdata <= m_snap[15:0];
          3'd5:    rdata <= m_snap[31:16];
          default: rdata <= 16'd0;
        endcase
      end else begin
        rdata <= 16'd0;
      end
    end
  end

  function automatic bus_t mk(input logic w, input logic [2:0] a, input logic [15:0] d);
    bus_t b;
    b.wr = w; b.addr = a; b.data = d;
    return b;
  endfunction

  // Monitor: every non-poll access is compared in order; polls (reads of STATUS) are free.
  logic chk_interval = 1'b0;
  int   last_tick    = -1;
  logic prev_sv      = 1'b0;
  always @(negedge clk) begin
    bus_t got, e;
    if (!reset_reset) begin
      if (cs && !(wn && addr == 3'd0)) begin
        got = mk(~wn, addr, wn ? 16'd0 : wdata);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_access got wr=%0d addr=%0d data=%h (none expected) cyc=%0d",
                   got.wr, got.addr, got.data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            bad++;
            $display("FAIL bus_access got wr=%0d addr=%0d data=%h want wr=%0d addr=%0d data=%h cyc=%0d",
                     got.wr, got.addr, got.data, e.wr, e.addr, e.data, cyc);
          end
        end
      end
      if (tick || (cs && !wn && addr == 3'd0)) begin
        total++;
        if (tick !== (cs && !wn && addr == 3'd0)) begin
          bad++;
          $display("FAIL tick_with_clear tick=%0d status_write=%0d cyc=%0d", tick,
                   (cs && !wn && addr == 3'd0), cyc);
        end
        if (tick && chk_interval) begin
          if (last_tick >= 0) begin
            total++;
            if ((cyc - last_tick) < 997 || (cyc - last_tick) > 1003) begin
              bad++;
              $display("FAIL tick_interval got %0d want 1000+-3", cyc - last_tick);
            end
          end
          last_tick = cyc;
        end
      end
      if (snap_valid) begin
        total++;
        if (prev_sv) begin
          bad++;
          $display("FAIL snap_valid_width got 2+ cycles want 1");
        end else if (snap_exp_q.size() == 0) begin
          bad++;
          $display("FAIL snap_unexpected got %h want none", snap_value);
        end else if (snap_value !== snap_exp_q[0]) begin
          bad++;
          $display("FAIL snap_value got %h want %h", snap_value, snap_exp_q[0]);
        end
        if (!prev_sv && snap_exp_q.size() != 0) void'(snap_exp_q.pop_front());
      end
      prev_sv = snap_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic send_cmd(input logic st, input logic sp, input logic sn, input logic [31:0] per);
    int n = 0;
    @(negedge clk);
    cfg_period = per; cmd_start = st; cmd_stop = sp; cmd_snap = sn;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) @(posedge clk);
    #1;
    cmd_start = 0; cmd_stop = 0; cmd_snap = 0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || snap_exp_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("drain_pending", exp_q.size() + snap_exp_q.size(), 32'd0);
  endtask

  task automatic start_then_stop(input logic [31:0] per, input logic [15:0] lo,
                                 input logic [15:0] hi);
    exp_q.push_back(mk(1, 3'd2, lo));
    exp_q.push_back(mk(1, 3'd3, hi));
    exp_q.push_back(mk(1, 3'd1, 16'h0006));
    exp_q.push_back(mk(1, 3'd1, 16'h0008));
    send_cmd(1, 0, 0, per);
    send_cmd(0, 1, 0, 32'd0);
    wait_drain(50);
    repeat (3) @(negedge clk);
    check("stopped_running", {31'd0, running}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    reset_reset = 1; cfg_period = 0; cmd_start = 0; cmd_stop = 0; cmd_snap = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_bus", {cs, wn, addr, wdata}, {1'b0, 1'b1, 3'd0, 16'd0});
    reset_reset = 0;
    @(negedge clk);
    check("rst_status", {running, tick, snap_valid}, 3'b000);
    check("rst_snap_value", snap_value, 32'd0);
    check("rst_tick_count", {16'd0, tick_count}, 32'd0);

    // Start with period 1000: writes on cycles 1..3, running and first poll on cycle 4.
    exp_q.push_back(mk(1, 3'd2, 16'h03E7));
    exp_q.push_back(mk(1, 3'd3, 16'h0000));
    exp_q.push_back(mk(1, 3'd1, 16'h0006));
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1, 3'd0, 16'h0000));
    chk_interval = 1'b1;
    send_cmd(1, 0, 0, 32'd1000);
    repeat (3) @(negedge clk);
    check("running_cycle3", {31'd0, running}, 32'd0);
    @(negedge clk);
    check("running_cycle4", {31'd0, running}, 32'd1);
    check("first_poll_cycle4", {cs, wn, addr}, {1'b1, 1'b1, 3'd0});
    wait_drain(6000);
    chk_interval = 1'b0;
`ifdef HAL_TIMER_TICK_COUNT_EN
    check("tick_count_5", {16'd0, tick_count}, 32'd5);
`else
    check("tick_count_off", {16'd0, tick_count}, 32'd0);
`endif

    // Snapshot while running, then polling must resume.
    exp_q.push_back(mk(1, 3'd4, 16'h0000));
    exp_q.push_back(mk(0, 3'd4, 16'h0000));
    exp_q.push_back(mk(0, 3'd5, 16'h0000));
    snap_exp_q.push_back(SnapConst);
    send_cmd(0, 0, 1, 32'd0);
    wait_drain(50);
    seen = 0; n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = cs && wn && addr == 3'd0;
      n++;
    end
    check("poll_resumes", {31'd0, seen}, 32'd1);
    check("running_after_snap", {31'd0, running}, 32'd1);

    // Stop and start together: only the STOP write, start ignored.
    exp_q.push_back(mk(1, 3'd1, 16'h0008));
    send_cmd(1, 1, 0, 32'd500);
    wait_drain(50);
    repeat (10) @(negedge clk);
    check("stop_wins_running", {31'd0, running}, 32'd0);
    check("stop_wins_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef HAL_TIMER_TICK_COUNT_EN
    check("tick_count_kept", {16'd0, tick_count}, 32'd5);
`endif

    // Period boundaries.
    start_then_stop(32'h0001_0000, 16'hFFFF, 16'h0000);
    start_then_stop(32'd0, 16'h0001, 16'h0000);

    // Reset during WR_PH aborts the sequence before the CONTROL write.
    exp_q.push_back(mk(1, 3'd2, 16'h03E7));
    exp_q.push_back(mk(1, 3'd3, 16'h0000));
    send_cmd(1, 0, 0, 32'd1000);
    @(negedge clk);
    @(negedge clk);
    check("in_wr_ph", {cs, wn, addr}, {1'b1, 1'b0, 3'd3});
    #1 reset_reset = 1;
    @(posedge clk);
    #1;
    check("abort_cs", {31'd0, cs}, 32'd0);
    check("abort_running", {31'd0, running}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    reset_reset = 0;
    repeat (10) @(negedge clk);
    check("abort_no_pending", exp_q.size(), 32'd0);
    check("abort_idle", {cs, running, cmd_ready}, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
